// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions
// and the FSM state type.
package alu_pkg;

  // Opcode encoding; 3'b111 is reserved and executes as PASS_B.
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Controller states: idle/single-cycle execution and multiply iteration.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/ripple_adder.sv
// Bit-level ripple-carry adder: a chain of WIDTH full adders.
module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR/XOR/PASS_B and an iterative
// shift-add unsigned multiply, with registered result, flags and a
// start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mul_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Add/subtract datapath: SUB is a + ~b + 1.
  logic             is_sub_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;

  assign is_sub_s = (op == OP_SUB);
  assign b_eff_s  = is_sub_s ? ~b : b;

  ripple_adder #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b_eff_s),
    .cin  (is_sub_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Multiply accumulation step: add multiplicand into the high half when
  // the current multiplier bit (low half LSB) is set.
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] mac_sum_s;
  logic             mac_cout_s;

  assign addend_s = acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}};

  ripple_adder #(.WIDTH(WIDTH)) u_mac (
    .a    (acc_hi_q),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (mac_sum_s),
    .cout (mac_cout_s)
  );

  // Accumulator after this step's add and right shift; on the final
  // iteration this is the full product.
  logic [WIDTH-1:0] prod_hi_s;
  logic [WIDTH-1:0] prod_lo_s;

  assign prod_hi_s = {mac_cout_s, mac_sum_s[WIDTH-1:1]};
  assign prod_lo_s = {mac_sum_s[0], acc_lo_q[WIDTH-1:1]};

  // Single-cycle op result and carry/overflow selection.
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;

  // Select the single-cycle result and arithmetic flags from the opcode.
  always_comb begin
    alu_res_s = b;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res_s = sum_s;
        alu_c_s   = cout_s;
        // Overflow: effective operands share a sign that the sum does not.
        alu_v_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      default: alu_res_s = b;
    endcase
  end

  // Next-state logic for the controller, multiply datapath and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    result_d = result_q;
    mul_hi_d = mul_hi_q;
    flags_d  = flags_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            acc_lo_d = b;
            acc_hi_d = {WIDTH{1'b0}};
            cnt_d    = {CW{1'b0}};
            busy_d   = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d        = alu_res_s;
            mul_hi_d        = {WIDTH{1'b0}};
            flags_d[FLAG_N] = alu_res_s[WIDTH-1];
            flags_d[FLAG_Z] = (alu_res_s == {WIDTH{1'b0}});
            flags_d[FLAG_C] = alu_c_s;
            flags_d[FLAG_V] = alu_v_s;
            done_d          = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MUL: begin
        acc_hi_d = prod_hi_s;
        acc_lo_d = prod_lo_s;
        if (cnt_q == LAST_CNT) begin
          result_d        = prod_lo_s;
          mul_hi_d        = prod_hi_s;
          flags_d[FLAG_N] = prod_lo_s[WIDTH-1];
          flags_d[FLAG_Z] = ({prod_hi_s, prod_lo_s} == {(2*WIDTH){1'b0}});
          flags_d[FLAG_C] = (prod_hi_s != {WIDTH{1'b0}});
          flags_d[FLAG_V] = 1'b0;
          done_d          = 1'b1;
          busy_d          = 1'b0;
          cnt_d           = {CW{1'b0}};
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = {CW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      mul_hi_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      result_q <= result_d;
      mul_hi_q <= mul_hi_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign mul_hi = mul_hi_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8 and WIDTH=16: directed
// scenarios followed by randomized ops against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;
  logic [3:0]  fl8;
  logic        start16, busy16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16, hi16;
  logic [3:0]  fl16;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .result(res8), .mul_hi(hi8), .flags(fl8), .busy(busy8), .done(done8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .result(res16), .mul_hi(hi16), .flags(fl16), .busy(busy16), .done(done16)
  );

  int n_assert = 0;
  int n_fail   = 0;
  longint unsigned prev_r[2];
  longint unsigned prev_h[2];
  logic [3:0]      prev_f[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  task automatic model(input int w, input logic [2:0] op, input longint unsigned a,
                       input longint unsigned b, output longint unsigned r,
                       output longint unsigned h, output logic [3:0] f);
    longint unsigned mask, s, p;
    int msb;
    logic n, z, c, v;
    mask = (64'd1 << w) - 64'd1;
    msb = w - 1;
    h = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = a + b; r = s & mask; c = s[w];
        v = (a[msb] == b[msb]) && (r[msb] != a[msb]);
      end
      3'd1: begin
        r = (a - b) & mask; c = (a >= b);
        v = (a[msb] != b[msb]) && (r[msb] != a[msb]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        p = a * b; r = p & mask; h = (p >> w) & mask; c = (h != 0);
      end
      default: r = b;
    endcase
    n = r[msb];
    z = (op == 3'd5) ? ((r == 0) && (h == 0)) : (r == 0);
    f = {n, z, c, v};
  endtask

  task automatic get_obs(input int sel, output longint unsigned r, output longint unsigned h,
                         output logic [3:0] f, output logic bz, output logic dn);
    if (sel == 0) begin
      r = {56'd0, res8}; h = {56'd0, hi8}; f = fl8; bz = busy8; dn = done8;
    end else begin
      r = {48'd0, res16}; h = {48'd0, hi16}; f = fl16; bz = busy16; dn = done16;
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [2:0] op,
                       input longint unsigned a, input longint unsigned b);
    if (sel == 0) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  // Issue one op; start is left high for single-cycle ops so the caller can
  // chain back-to-back issues. hold keeps an ADD request asserted during MUL.
  task automatic run_op(input int sel, input logic [2:0] op, input longint unsigned a,
                        input longint unsigned b, input bit hold);
    int w, busy_cnt;
    longint unsigned r, h, er, eh;
    logic [3:0] f, ef;
    logic bz, dn;
    w = (sel == 0) ? 8 : 16;
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    if (op == OP_MUL) begin
      if (hold) drive(sel, 1'b1, OP_ADD, 64'd1, 64'd1);
      else drive(sel, 1'b0, OP_ADD, 64'd0, 64'd0);
      busy_cnt = 0;
      get_obs(sel, r, h, f, bz, dn);
      while (!dn && busy_cnt < 3 * w) begin
        chk("busy_during_mul", {63'd0, bz}, 64'd1);
        chk("result_hold", r, prev_r[sel]);
        chk("flags_hold", {60'd0, f}, {60'd0, prev_f[sel]});
        busy_cnt++;
        @(posedge clk); #1;
        get_obs(sel, r, h, f, bz, dn);
      end
      drive(sel, 1'b0, OP_ADD, 64'd0, 64'd0);
      chk("busy_cycles", busy_cnt, w);
      chk("busy_clear", {63'd0, bz}, 64'd0);
    end
    get_obs(sel, r, h, f, bz, dn);
    model(w, op, a, b, er, eh, ef);
    chk("done", {63'd0, dn}, 64'd1);
    chk("result", r, er);
    chk("mul_hi", h, eh);
    chk("flags", {60'd0, f}, {60'd0, ef});
    prev_r[sel] = er; prev_h[sel] = eh; prev_f[sel] = ef;
  endtask

  // Drop start for one cycle and confirm done falls with outputs held.
  task automatic idle(input int sel);
    longint unsigned r, h;
    logic [3:0] f;
    logic bz, dn;
    drive(sel, 1'b0, OP_ADD, 64'd0, 64'd0);
    @(posedge clk); #1;
    get_obs(sel, r, h, f, bz, dn);
    chk("done_fall", {63'd0, dn}, 64'd0);
    chk("idle_result_hold", r, prev_r[sel]);
    chk("idle_mulhi_hold", h, prev_h[sel]);
  endtask

  initial begin
    int sel, last_sel;
    logic [2:0] op;
    longint unsigned ra, rb;

    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    drive(1, 1'b0, OP_ADD, 64'd0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      prev_r[i] = 0; prev_h[i] = 0; prev_f[i] = 4'd0;
    end

    // Reset state
    #12;
    chk("rst_result8", {56'd0, res8}, 64'd0);
    chk("rst_mulhi8", {56'd0, hi8}, 64'd0);
    chk("rst_flags8", {60'd0, fl8}, 64'd0);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_result16", {48'd0, res16}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD wrap to zero, then done must drop
    run_op(0, OP_ADD, 64'hFF, 64'h01, 1'b0);
    chk("add_ff_01", {56'd0, res8}, 64'h00);
    chk("add_ff_01_flags", {60'd0, fl8}, 64'b0110);
    idle(0);

    // SUB overflow and SUB borrow
    run_op(0, OP_SUB, 64'h80, 64'h01, 1'b0);
    chk("sub_80_01_flags", {60'd0, fl8}, 64'b0011);
    idle(0);
    run_op(0, OP_SUB, 64'h00, 64'h01, 1'b0);
    chk("sub_00_01", {56'd0, res8}, 64'hFF);
    chk("sub_00_01_flags", {60'd0, fl8}, 64'b1000);
    idle(0);

    // MUL with an ADD request held during busy
    run_op(0, OP_MUL, 64'hFF, 64'hFF, 1'b1);
    chk("mul_ff_ff_hi", {56'd0, hi8}, 64'hFE);
    chk("mul_ff_ff_lo", {56'd0, res8}, 64'h01);
    idle(0);

    // Back-to-back logic ops: done continuously high
    run_op(0, OP_AND, 64'hF0, 64'h3C, 1'b0);
    chk("and", {56'd0, res8}, 64'h30);
    run_op(0, OP_OR, 64'hF0, 64'h3C, 1'b0);
    chk("or", {56'd0, res8}, 64'hFC);
    run_op(0, OP_XOR, 64'hF0, 64'h3C, 1'b0);
    chk("xor", {56'd0, res8}, 64'hCC);
    run_op(0, OP_PASSB, 64'h00, 64'hA5, 1'b0);
    chk("passb", {56'd0, res8}, 64'hA5);
    idle(0);

    // Reset in the middle of a MUL
    drive(0, 1'b1, OP_MUL, 64'hFF, 64'hFF);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result8", {56'd0, res8}, 64'd0);
    chk("arst_mulhi8", {56'd0, hi8}, 64'd0);
    chk("arst_flags8", {60'd0, fl8}, 64'd0);
    chk("arst_busy8", {63'd0, busy8}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      prev_r[i] = 0; prev_h[i] = 0; prev_f[i] = 4'd0;
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {63'd0, done8}, 64'd0);
    end
    run_op(0, OP_ADD, 64'h02, 64'h03, 1'b0);
    chk("add_after_abort", {56'd0, res8}, 64'h05);
    idle(0);

    // 16-bit multiply
    run_op(1, OP_MUL, 64'h1234, 64'h0010, 1'b0);
    chk("mul16_lo", {48'd0, res16}, 64'h2340);
    chk("mul16_hi", {48'd0, hi16}, 64'h0001);
    chk("mul16_flags", {60'd0, fl16}, 64'b0010);
    idle(1);

    // Randomized ops on both widths, with boundary operands mixed in
    last_sel = 0;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 0;
        1: rb = (sel == 0) ? 64'hFF : 64'hFFFF;
        2: ra = (sel == 0) ? 64'h80 : 64'h8000;
        default: ra = ra;
      endcase
      ra = ra & ((sel == 0) ? 64'hFF : 64'hFFFF);
      rb = rb & ((sel == 0) ? 64'hFF : 64'hFFFF);
      if (sel != last_sel) idle(last_sel);
      run_op(sel, op, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(sel);
      last_sel = sel;
    end
    idle(last_sel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised sequential ALU for the SimpleCPU datapath. It replaces the fixed 8-bit combinational adder and 2:1 operand mux with one registered execution unit. Single-cycle ops: ADD, SUB, AND, OR, XOR, PASS_B. Iterative op: unsigned shift-add MUL. Status flags N/Z/C/V are produced for every op. The control unit issues one op at a time through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: issue request. Sampled only when `busy`=0.
- `op` in 3: opcode, captured with `start`.
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 PASS_B.
  - 111 reserved; executes as PASS_B.
- `a` in WIDTH: operand A, captured with `start`.
- `b` in WIDTH: operand B, captured with `start`.
- `result` out WIDTH: registered result. Holds the low half of the product for MUL.
- `mul_hi` out WIDTH: registered high half of the MUL product; 0 for all other ops.
- `flags` out 4: registered {N,Z,C,V}, bits [3:0].
- `busy` out 1: high while a MUL is iterating.
- `done` out 1: one-cycle pulse; `result`/`mul_hi`/`flags` are updated on the same edge.

## Operation
- FSM states: IDLE and MUL.
- **IDLE**
  - `start`=1 with a single-cycle op: compute from `a`/`b` and write `result`, `mul_hi`=0, `flags`, `done`=1 at that edge; stay in IDLE.
  - `start`=1 with MUL: capture `a` into multiplicand, `b` into multiplier shift register, clear accumulator; set `busy`=1; go to MUL. `done`=0.
  - `start`=0: `done`=0; outputs hold.
- **MUL** (WIDTH iterations, counter 0..WIDTH-1)
  - Each edge: if multiplier LSB is 1, add multiplicand to the accumulator high half using a (WIDTH+1)-bit add that keeps the carry.
  - Then shift {carry, acc_hi, acc_lo/multiplier} right by 1.
  - On the last iteration: write the 2·WIDTH product to {`mul_hi`,`result`}, write `flags`, set `done`=1, set `busy`=0, return to IDLE.
- While `busy`=1, `start`, `op`, `a` and `b` are ignored.
- Flags:
  - N = `result`[WIDTH-1].
  - Z = (`result`==0). For MUL, Z = ({`mul_hi`,`result`}==0).
  - ADD: C = carry out; V = signed overflow (operands have the same sign and the result sign differs).
  - SUB: computed as a + ~b + 1. C = carry out (1 = no borrow); V = signed overflow (operands have different signs and the result sign ≠ sign of a).
  - AND/OR/XOR/PASS_B: C=0, V=0.
  - MUL: C = (`mul_hi`≠0), V=0.
- Arithmetic is modulo 2^WIDTH with no saturation.

## Timing
- Reset values: `result`=0, `mul_hi`=0, `flags`=0, `busy`=0, `done`=0; state IDLE; MUL counter 0.
- Reset asserted mid-MUL aborts the op immediately; no `done` is produced.
- Single-cycle op, `start` sampled at edge k: outputs and `done`=1 are visible after edge k; latency 1.
  - `done` falls after edge k+1 unless `start` is high again.
  - Back-to-back issue every cycle is legal, giving `done` continuously high.
- MUL, `start` sampled at edge k:
  - `busy`=1 from after edge k through after edge k+WIDTH-1.
  - Product, `flags`, and `done`=1 appear after edge k+WIDTH; `busy`=0 in the same cycle.
  - A new `start` may be sampled at edge k+WIDTH+1.
- `result`/`mul_hi`/`flags` hold their last values between ops and during MUL iterations. Intermediates stay internal.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams: OP_ADD … OP_PASSB.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module `ripple_adder #(WIDTH)` with ports a, b, cin, sum, cout: bit-level full-adder chain.
  - Instance 1: ADD/SUB, with b or ~b and cin 0 or 1.
  - Instance 2: MUL accumulation step.
- The FSM, counter and shift register live in `seq_alu`.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 -> after one edge: `result`=0x00, flags N0 Z1 C1 V0, `done` pulse of 1 cycle.
- SUB 0x80−0x01 -> `result`=0x7F, N0 Z0 C1 V1. Then SUB 0x00−0x01 -> 0xFF, N1 C0 V0.
- MUL 0xFF×0xFF -> `busy` high exactly 8 cycles; then `mul_hi`=0xFE, `result`=0x01, C1 Z0.
  - A `start` with ADD held during `busy` is ignored; outputs are unchanged until `done`.
- Back-to-back in consecutive cycles: AND 0xF0&0x3C, OR, XOR, PASS_B 0xA5 -> 0x30, 0xFC, 0xCC, 0xA5.
  - `done` stays high for 4 cycles; C=V=0 throughout.
- `rst_n` low at iteration 4 of a MUL -> all outputs 0 asynchronously; no `done` after release.
  - A following ADD 0x02+0x03 -> 0x05.
- WIDTH=16, MUL 0x1234×0x0010 -> after 16 cycles: `result`=0x2340, `mul_hi`=0x0001, C1.
